// File: rtl/fc_neuron_acc.sv
// fc_neuron_acc: reduction stage of the FC-as-1x1-conv path.
// Accumulates N_IN signed products plus a signed bias into one neuron
// pre-activation and presents it, with its binarized sign, on a
// valid/ready output.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   product beat handshake
//   prod_in  [IN_W]       signed product (pixel x +/-1)
//   bias_in  [ACC_W]      signed bias, sampled on the first beat only
//   out_valid / out_ready result handshake
//   acc_out  [ACC_W]      bias + sum of products
//   sign_out              1 when acc_out >= 0 (only while out_valid)
//   ovf_flag              sticky per-neuron overflow indicator
//
// Macro FC_ACC_SAT_EN: when defined, overflowing adds clamp to the
// ACC_W-bit signed range; otherwise they wrap modulo 2^ACC_W.
module fc_neuron_acc #(
    parameter int unsigned N_IN  = 64,
    parameter int unsigned IN_W  = 9,
    parameter int unsigned ACC_W = 12,
    parameter int unsigned CNT_W = $clog2(N_IN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  prod_in,
    input  logic [ACC_W-1:0] bias_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             sign_out,
    output logic             ovf_flag
);

    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_base_c;
    logic [SUM_W-1:0]   sum_c;
    logic               add_ovf_c;
    logic [ACC_W-1:0]   add_res_c;
    logic               accept_c;

    // Adder: the first beat of a neuron starts from the bias, later beats from acc.
    always_comb begin
        add_base_c = (state_q == S_IDLE) ? bias_in : acc_q;
        sum_c      = {add_base_c[ACC_W-1], add_base_c}
                   + {{(SUM_W-IN_W){prod_in[IN_W-1]}}, prod_in};
        add_ovf_c  = sum_c[SUM_W-1] ^ sum_c[ACC_W-1];
`ifdef FC_ACC_SAT_EN
        // Clamp toward the sign of the true (ACC_W+1)-bit sum.
        if (add_ovf_c) begin
            add_res_c = sum_c[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                       : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            add_res_c = sum_c[ACC_W-1:0];
        end
`else
        add_res_c = sum_c[ACC_W-1:0];
`endif
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        accept_c = in_valid && (state_q != S_DONE);
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    acc_d   = add_res_c;
                    ovf_d   = add_ovf_c;   // fresh neuron clears the sticky flag
                    count_d = CNT_W'(1);
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept_c) begin
                    acc_d = add_res_c;
                    ovf_d = ovf_q | add_ovf_c;
                    if (count_q == CNT_W'(N_IN - 1)) begin
                        count_d = '0;
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state; sign is only asserted with a result.
    always_comb begin
        in_ready  = (state_q != S_DONE);
        out_valid = (state_q == S_DONE);
        acc_out   = acc_q;
        sign_out  = (state_q == S_DONE) && !acc_q[ACC_W-1];
        ovf_flag  = ovf_q;
    end

endmodule

// File: tb/tb_fc_neuron_acc.sv
module tb_fc_neuron_acc;

    localparam int AMAX = 2047;
    localparam int AMIN = -2048;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // N_IN=4 instance
    logic        iv4, ir4, ov4, or4, sg4, of4;
    logic [8:0]  pr4;
    logic [11:0] bi4, acc4;
    // N_IN=64 instance
    logic        iv64, ir64, ov64, or64, sg64, of64;
    logic [8:0]  pr64;
    logic [11:0] bi64, acc64;

    fc_neuron_acc #(.N_IN(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .prod_in(pr4), .bias_in(bi4), .out_valid(ov4), .out_ready(or4),
        .acc_out(acc4), .sign_out(sg4), .ovf_flag(of4)
    );

    fc_neuron_acc #(.N_IN(64)) u_d64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .prod_in(pr64), .bias_in(bi64), .out_valid(ov64), .out_ready(or64),
        .acc_out(acc64), .sign_out(sg64), .ovf_flag(of64)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // One add in the chosen arithmetic mode; sets ovf when the true sum leaves range.
    function automatic void add_step(inout int run, inout bit ovf, input int p);
        int t;
        t = run + p;
        if (t > AMAX || t < AMIN) begin
            ovf = 1'b1;
`ifdef FC_ACC_SAT_EN
            run = (t > AMAX) ? AMAX : AMIN;
`else
            run = (t > AMAX) ? t - 4096 : t + 4096;
`endif
        end else begin
            run = t;
        end
    endfunction

    // Reference model for the N_IN=4 instance: beats seen, running sum, result pending.
    int m_beats;
    int m_run;
    bit m_ovf;
    bit m_done;
    bit check_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_beats = 0; m_run = 0; m_ovf = 0; m_done = 0;
        end else if (m_done) begin
            if (or4) m_done = 0;
        end else if (iv4) begin
            if (m_beats == 0) begin
                m_run = int'($signed(bi4));
                m_ovf = 0;
            end
            add_step(m_run, m_ovf, int'($signed(pr4)));
            m_beats++;
            if (m_beats == 4) begin
                m_done  = 1;
                m_beats = 0;
            end
        end
    end

    // Compare process: handshake every cycle, result fields while a result is held.
    always @(negedge clk) begin
        if (check_en) begin
            chk("in_ready", int'(ir4), int'(!m_done));
            chk("out_valid", int'(ov4), int'(m_done));
            if (m_done) begin
                chk("acc_out", int'($signed(acc4)), m_run);
                chk("sign_out", int'(sg4), int'(m_run >= 0));
                chk("ovf_flag", int'(of4), int'(m_ovf));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send_beat(input logic [11:0] b, input logic [8:0] p, input bit gaps);
        int k;
        if (gaps) begin
            iv4 = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                or4 = 1'($urandom_range(0, 1));
                cyc();
            end
        end
        iv4 = 1'b1; bi4 = b; pr4 = p;
        or4 = 1'($urandom_range(0, 1));
        k = 0;
        while (!ir4 && k < 50) begin cyc(); k++; end
        if (!ir4) chk("beat_timeout", 0, 1);
        cyc();
        iv4 = 1'b0;
        bi4 = 12'($urandom);
        pr4 = 9'($urandom);
    endtask

    task automatic send_neuron(input int bias, input int p0, input int p1,
                               input int p2, input int p3, input bit gaps);
        send_beat(12'(bias), 9'(p0), gaps);
        send_beat(12'($urandom), 9'(p1), gaps);
        send_beat(12'($urandom), 9'(p2), gaps);
        send_beat(12'($urandom), 9'(p3), gaps);
    endtask

    task automatic wait_valid();
        int k = 0;
        or4 = 1'b0;
        while (!ov4 && k < 50) begin cyc(); k++; end
        if (!ov4) chk("result_timeout", 0, 1);
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        bit done = 0;
        while (!done && k < 50) begin
            or4 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done = ov4 && or4;
            cyc();
            k++;
        end
        if (!done) chk("drain_timeout", 0, 1);
        or4 = 1'b0;
    endtask

    initial begin
        int run64;
        bit ovf64;
        rst_n = 1'b0;
        iv4 = 0; or4 = 0; pr4 = '0; bi4 = '0;
        iv64 = 0; or64 = 0; pr64 = '0; bi64 = '0;
        repeat (3) cyc();

        // Reset state
        chk("rst_acc", int'(acc4), 0);
        chk("rst_sign", int'(sg4), 0);
        chk("rst_ovf", int'(of4), 0);
        chk("rst_out_valid", int'(ov4), 0);
        chk("rst_in_ready", int'(ir4), 1);
        rst_n = 1'b1;
        check_en = 1'b1;

        // bias 5, prods 10,-3,7,1, continuous in_valid
        iv4 = 1; bi4 = 12'd5; pr4 = 9'd10; cyc();
        bi4 = 12'd999; pr4 = -9'sd3; cyc();
        pr4 = 9'd7; cyc();
        chk("t1_not_yet_valid", int'(ov4), 0);
        pr4 = 9'd1; cyc();
        iv4 = 0;
        chk("t1_valid_after_4", int'(ov4), 1);
        chk("t1_acc", int'($signed(acc4)), 20);
        chk("t1_sign", int'(sg4), 1);
        chk("t1_ovf", int'(of4), 0);
        drain(0);

        // four beats of -255
        send_neuron(0, -255, -255, -255, -255, 0);
        wait_valid();
        chk("t2_acc_hex", int'(acc4), 32'hC04);
        chk("t2_sign", int'(sg4), 0);
        drain(0);

        // Back-pressure in DONE with new data pending
        send_neuron(2, 1, 2, 3, 4, 0);
        wait_valid();
        iv4 = 1; bi4 = 12'd100; pr4 = 9'd7; or4 = 0;
        repeat (3) begin
            cyc();
            chk("bp_in_ready", int'(ir4), 0);
            chk("bp_acc_stable", int'($signed(acc4)), 12);
        end
        or4 = 1; cyc(); or4 = 0;
        chk("bp_ready_after_hs", int'(ir4), 1);
        cyc(); iv4 = 0;
        send_beat(12'($urandom), 9'd7, 0);
        send_beat(12'($urandom), 9'd7, 0);
        send_beat(12'($urandom), 9'd7, 0);
        wait_valid();
        chk("bp_next_acc", int'($signed(acc4)), 128);
        drain(0);

        // Reset mid-neuron
        send_beat(12'd50, 9'd9, 0);
        send_beat(12'd0, 9'd9, 0);
        rst_n = 0; cyc(); rst_n = 1;
        chk("mid_rst_out_valid", int'(ov4), 0);
        chk("mid_rst_in_ready", int'(ir4), 1);
        send_neuron(0, 1, 1, 1, 1, 0);
        wait_valid();
        chk("mid_rst_acc", int'($signed(acc4)), 4);
        drain(0);

        // Gapped input, bias -4
        send_neuron(-4, 1, 1, 1, 1, 1);
        wait_valid();
        chk("gap_acc", int'($signed(acc4)), 0);
        chk("gap_sign", int'(sg4), 1);
        drain(1);

        // Extreme input -256 and overflow corners
        send_neuron(-2048, -256, -256, 255, 1, 1);
        drain(1);
        send_neuron(2047, 255, -256, -256, -256, 1);
        drain(1);

        // Randomized neurons
        for (int n = 0; n < 30; n++) begin
            send_neuron($urandom_range(0, 4095) - 2048,
                        $urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256,
                        $urandom_range(0, 511) - 256, $urandom_range(0, 511) - 256,
                        1'($urandom_range(0, 1)));
            drain(1);
        end

        // N_IN=64, 64 beats of +255
        iv64 = 1; bi64 = 12'd0; pr64 = 9'd255;
        run64 = 0; ovf64 = 0;
        for (int i = 0; i < 64; i++) begin
            add_step(run64, ovf64, 255);
            cyc();
        end
        iv64 = 0;
        chk("n64_valid", int'(ov64), 1);
        chk("n64_acc_model", int'($signed(acc64)), run64);
`ifdef FC_ACC_SAT_EN
        chk("n64_acc", int'($signed(acc64)), 2047);
        chk("n64_sign", int'(sg64), 1);
`else
        chk("n64_acc", int'(acc64), 4032);
        chk("n64_sign", int'(sg64), 0);
`endif
        chk("n64_ovf", int'(of64), 1);
        or64 = 1; cyc(); or64 = 0;
        chk("n64_idle", int'(ir64), 1);

        check_en = 1'b0;
        cyc();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
